// File: rtl/image_mem_loader_if.sv
// Host-side bus bundle of the image loader: control, rx stream, data-memory
// port, CPU handshake and tx stream. master = loader, slave = surroundings.
interface image_mem_loader_if;
    logic        start;
    logic        busy;
    logic        done;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    logic        cpu_run;
    logic        cpu_done;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  start, rx_data, rx_valid, mem_rdata, cpu_done, tx_ready,
        output busy, done, rx_ready, mem_addr, mem_wdata, mem_we, mem_re,
               cpu_run, tx_data, tx_valid
    );

    modport slave (
        output start, rx_data, rx_valid, mem_rdata, cpu_done, tx_ready,
        input  busy, done, rx_ready, mem_addr, mem_wdata, mem_we, mem_re,
               cpu_run, tx_data, tx_valid
    );
endinterface

// File: rtl/image_mem_loader.sv
// Loads an image byte stream into data memory, hands memory to the CPU,
// then streams the result region back out one byte per read/wait/send cycle.
module image_mem_loader #(
    parameter logic [15:0] IN_BASE  = 16'd0,
    parameter logic [15:0] IN_LEN   = 16'd16384,
    parameter logic [15:0] OUT_BASE = 16'd16384,
    parameter logic [15:0] OUT_LEN  = 16'd4096
) (
    input  logic                clk,
    input  logic                rst_n,
    image_mem_loader_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_TX,
        FINISH
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  tx_q, tx_nx;
    logic        run_q, run_nx;

    logic        rx_ready_c;
    logic [15:0] mem_addr_c;
    logic [7:0]  mem_wdata_c;
    logic        mem_we_c;
    logic        mem_re_c;
    logic        tx_valid_c;
    logic        done_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            tx_q  <= '0;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tx_q  <= tx_nx;
            run_q <= run_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tx_nx       = tx_q;
        run_nx      = 1'b0;
        rx_ready_c  = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        tx_valid_c  = 1'b0;
        done_c      = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end

            // Write strobe follows rx_valid directly so each accepted byte
            // lands in memory on the same cycle it is handshaken.
            LOAD: begin
                rx_ready_c  = 1'b1;
                mem_we_c    = bus.rx_valid;
                mem_addr_c  = IN_BASE + cnt;
                mem_wdata_c = bus.rx_data;
                if (bus.rx_valid) begin
                    if (cnt == IN_LEN - 16'd1) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        run_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end

            RUN: begin
                run_nx = 1'b1;
                if (bus.cpu_done) begin
                    state_nx = DUMP_RD;
                    cnt_nx   = '0;
                    run_nx   = 1'b0;
                end
            end

            DUMP_RD: begin
                mem_re_c   = 1'b1;
                mem_addr_c = OUT_BASE + cnt;
                state_nx   = DUMP_WAIT;
            end

            DUMP_WAIT: begin
                tx_nx    = bus.mem_rdata;
                state_nx = DUMP_TX;
            end

            DUMP_TX: begin
                tx_valid_c = 1'b1;
                if (bus.tx_ready) begin
                    if (cnt == OUT_LEN - 16'd1) begin
                        state_nx = FINISH;
                    end else begin
                        cnt_nx   = cnt + 16'd1;
                        state_nx = DUMP_RD;
                    end
                end
            end

            FINISH: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_c;
    assign bus.rx_ready  = rx_ready_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_re    = mem_re_c;
    assign bus.cpu_run   = run_q;
    assign bus.tx_data   = tx_q;
    assign bus.tx_valid  = tx_valid_c;

endmodule

// File: tb/tb_image_mem_loader.sv
// Directed bench for image_mem_loader: load, run handoff, dump with
// back-pressure, spurious inputs and asynchronous reset mid-dump.
module tb_image_mem_loader;

    logic clk;
    logic rst_n;

    image_mem_loader_if bus ();

    image_mem_loader #(
        .IN_BASE  (16'h0000),
        .IN_LEN   (16'd4),
        .OUT_BASE (16'h0010),
        .OUT_LEN  (16'd3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int n_wr  = 0;
    int n_rd  = 0;
    int n_done = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] load_bytes [0:3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory plus strobe counters.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            n_wr <= n_wr + 1;
        end
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            n_rd <= n_rd + 1;
        end
        if (bus.done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cpu_done = 1'b0;
        bus.tx_ready = 1'b0;
        mem[16'h0010] = 8'hA0;
        mem[16'h0011] = 8'hA1;
        mem[16'h0012] = 8'hA2;
        load_bytes[0] = 8'h11;
        load_bytes[1] = 8'h22;
        load_bytes[2] = 8'h33;
        load_bytes[3] = 8'h44;

        #3;
        chk("rst_busy",     bus.busy,     0);
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_mem_re",   bus.mem_re,   0);
        chk("rst_cpu_run",  bus.cpu_run,  0);
        chk("rst_tx_data",  bus.tx_data,  0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_done",     bus.done,     0);

        // Basic load with rx_valid held high; spurious start/cpu_done mid-load.
        step;
        rst_n     = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("idle_busy", bus.busy, 0);
        step;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = load_bytes[0];
        #1;
        chk("load_busy",     bus.busy,      1);
        chk("load_rx_ready", bus.rx_ready,  1);
        chk("load0_we",      bus.mem_we,    1);
        chk("load0_addr",    bus.mem_addr,  0);
        chk("load0_wdata",   bus.mem_wdata, 8'h11);
        for (int i = 1; i < 4; i++) begin
            step;
            bus.rx_data  = load_bytes[i];
            bus.start    = (i == 1);
            bus.cpu_done = (i == 2);
            #1;
            chk("load_we",    bus.mem_we,    1);
            chk("load_addr",  bus.mem_addr,  i);
            chk("load_wdata", bus.mem_wdata, load_bytes[i]);
        end
        step;
        bus.start    = 1'b0;
        bus.cpu_done = 1'b0;
        bus.rx_data  = 8'h99;
        #1;
        chk("run_cpu_run",  bus.cpu_run,  1);
        chk("run_rx_ready", bus.rx_ready, 0);
        chk("run_mem_we",   bus.mem_we,   0);
        chk("run_mem_re",   bus.mem_re,   0);
        chk("run_busy",     bus.busy,     1);
        chk("load_nwr",     n_wr,         4);
        chk("load_mem3",    mem[3],       8'h44);
        step;
        step;
        chk("run_hold_cpu_run", bus.cpu_run, 1);
        chk("run_hold_we",      bus.mem_we,  0);
        chk("run_hold_nwr",     n_wr,        4);

        // Hand back from the CPU and dump three bytes.
        bus.rx_valid = 1'b0;
        bus.cpu_done = 1'b1;
        step;
        bus.cpu_done = 1'b0;
        #1;
        chk("rd0_cpu_run", bus.cpu_run,  0);
        chk("rd0_re",      bus.mem_re,   1);
        chk("rd0_we",      bus.mem_we,   0);
        chk("rd0_addr",    bus.mem_addr, 16'h0010);
        chk("rd0_txv",     bus.tx_valid, 0);
        step;
        chk("wait0_re",  bus.mem_re,   0);
        chk("wait0_txv", bus.tx_valid, 0);
        step;
        bus.tx_ready = 1'b1;
        #1;
        chk("tx0_valid", bus.tx_valid, 1);
        chk("tx0_data",  bus.tx_data,  8'hA0);
        step;
        bus.tx_ready = 1'b0;
        #1;
        chk("rd1_re",   bus.mem_re,   1);
        chk("rd1_addr", bus.mem_addr, 16'h0011);
        chk("rd1_txv",  bus.tx_valid, 0);
        step;
        step;
        for (int k = 0; k < 5; k++) begin
            bus.cpu_done = (k == 2);
            #1;
            chk("bp_txv",  bus.tx_valid, 1);
            chk("bp_data", bus.tx_data,  8'hA1);
            chk("bp_re",   bus.mem_re,   0);
            step;
        end
        bus.cpu_done = 1'b0;
        bus.tx_ready = 1'b1;
        #1;
        chk("tx1_valid", bus.tx_valid, 1);
        chk("tx1_data",  bus.tx_data,  8'hA1);
        chk("bp_nrd",    n_rd,         2);
        step;
        chk("rd2_re",   bus.mem_re,   1);
        chk("rd2_addr", bus.mem_addr, 16'h0012);
        step;
        step;
        chk("tx2_valid", bus.tx_valid, 1);
        chk("tx2_data",  bus.tx_data,  8'hA2);
        step;
        chk("fin_done", bus.done,     1);
        chk("fin_busy", bus.busy,     1);
        chk("fin_txv",  bus.tx_valid, 0);
        step;
        chk("idle_done",   bus.done, 0);
        chk("idle_busy2",  bus.busy, 0);
        chk("dump_ndone",  n_done,   1);
        chk("dump_nrd",    n_rd,     3);
        bus.tx_ready = 1'b0;

        // Back-pressured load: rx_valid pattern 1,0,0,1,0,0,...
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.rx_valid = ((k % 3) == 0);
            bus.rx_data  = 8'h50 + 8'(k);
            #1;
            chk("bpl_we", bus.mem_we, ((k % 3) == 0));
            if ((k % 3) == 0) begin
                chk("bpl_addr",  bus.mem_addr,  k / 3);
                chk("bpl_wdata", bus.mem_wdata, 8'h50 + k);
            end
            step;
        end
        bus.rx_valid = 1'b0;
        #1;
        chk("bpl_cpu_run", bus.cpu_run, 1);
        chk("bpl_mem1",    mem[1],      8'h53);
        chk("bpl_mem3",    mem[3],      8'h59);
        chk("bpl_nwr",     n_wr,        8);

        // Reset asserted while a byte is being offered.
        bus.cpu_done = 1'b1;
        step;
        bus.cpu_done = 1'b0;
        step;
        step;
        chk("pre_rst_txv", bus.tx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_txv",     bus.tx_valid, 0);
        chk("arst_tx_data", bus.tx_data,  0);
        chk("arst_busy",    bus.busy,     0);
        chk("arst_cpu_run", bus.cpu_run,  0);
        chk("arst_re",      bus.mem_re,   0);
        chk("arst_addr",    bus.mem_addr, 0);
        step;
        rst_n     = 1'b1;
        bus.start = 1'b1;
        step;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        #1;
        chk("restart_rx_ready", bus.rx_ready, 1);
        chk("restart_we",       bus.mem_we,   1);
        chk("restart_addr",     bus.mem_addr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
